alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width in bits, which is also the serial length.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request; sampled only in IDLE.
REQ-005 SHALL have port opcode_in, input, 3 bits: ALU opcode, latched at accept.
REQ-006 SHALL have port a_in, input, WIDTH bits: operand A, latched at accept.
REQ-007 SHALL have port b_in, input, WIDTH bits: operand B, latched at accept.
REQ-008 SHALL have port busy, output, 1 bit: high from the accept edge until the SAMPLE state exits.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; result and carry are valid from this cycle on.
REQ-010 SHALL have port result, output, WIDTH bits: parallel y word, held until the next done.
REQ-011 SHALL have port carry, output, 1 bit: ALU c sampled after the last bit, held until the next done.
REQ-012 SHALL have port ovr, output, 1 bit: overrun flag (see Configuration).
REQ-013 SHALL have port alu_rst_n, output, 1 bit: active-low clear to the bit-serial ALU.
REQ-014 SHALL have port alu_opcode, output, 3 bits: latched opcode, held stable for the whole operation.
REQ-015 SHALL have ports alu_a and alu_b, output, 1 bit each: serial operand bits, LSB first.
REQ-016 SHALL have ports alu_y and alu_c, input, 1 bit each: serial result bit and carry/flag from the ALU.

Function
REQ-017 SHALL implement states IDLE, CLEAR, SHIFT and SAMPLE; the done cycle is spent in IDLE.
REQ-018 IDLE with start=1 SHALL, at the edge: latch opcode_in, a_in and b_in; clear the y shift register; set busy=1; go to CLEAR.
REQ-019 CLEAR SHALL last 1 cycle with alu_rst_n=0, then go to SHIFT with bit counter=0.
REQ-020 SHIFT SHALL last exactly WIDTH cycles with alu_rst_n=1.
REQ-021 In each SHIFT cycle, alu_a/alu_b SHALL equal bit 0 of the operand shift registers.
REQ-022 At each SHIFT edge, the block SHALL shift both operands right by 1 and shift the y register as {alu_y, y[WIDTH-1:1]}.
REQ-023 SHIFT SHALL go to SAMPLE when the bit counter reaches WIDTH-1.
REQ-024 SAMPLE SHALL last 1 cycle; at its exit edge: result<=y register, carry<=alu_c, done<=1, busy<=0, state<=IDLE.
REQ-025 Latency SHALL be fixed: done is high WIDTH+3 cycles after the accept edge (11 cycles for WIDTH=8); there is no data-dependent timing.
REQ-026 start SHALL be ignored while busy=1, with no effect on the running operation.
REQ-027 A start during the done cycle SHALL be accepted, allowing back-to-back operations every WIDTH+3 cycles.
REQ-028 The block SHALL NOT interpret the opcode; carry SHALL be the raw alu_c for all opcodes, including opcodes 1 and 7.
REQ-029 Outside CLEAR and reset, alu_rst_n SHALL be 1; in IDLE, alu_a and alu_b SHALL be 0.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=IDLE, busy=0, done=0, result=0, carry=0, ovr=0, counter=0 and all shift registers to 0.
REQ-031 alu_rst_n SHALL be 0 whenever rst=1, regardless of state.
REQ-032 A reset mid-operation SHALL abort the operation with no done pulse; the next accepted start SHALL run normally.

Configuration
REQ-033 With macro ALU_SEQUENCER_OVR_EN defined, ovr SHALL be set when start=1 while busy=1, and SHALL stay set until reset or the next accepted start.
REQ-034 Without ALU_SEQUENCER_OVR_EN, ovr SHALL be constant 0 and the detect logic SHALL be absent.

Verification (bench connects the team's bit-serial alu; WIDTH=8)
REQ-035 Addition: opcode 0, a=200, b=100 -> done 11 cycles after accept, result=44, carry=1.
REQ-036 Compare: opcode 6, a=9, b=4 -> result=9, carry=1. Equality: opcode 5, a=b=0x5A -> result=0x5A, carry=1.
REQ-037 Subtraction, back-to-back: opcode 1, a=5, b=3 with start held high -> result=2 at the first done; a second operation is accepted in the done cycle and its done comes exactly 11 cycles later.
REQ-038 Reset mid-operation: rst pulsed at SHIFT bit 3 of opcode 0, a=0xFF, b=0x01 -> busy=0, no done, result=0; a following opcode 2, a=0x0F, b=0xF0 -> result=0xFF, carry=1.
REQ-039 Start while busy: start pulsed 4 cycles after accept -> first result unaffected and no extra done; ovr=1 with ALU_SEQUENCER_OVR_EN defined, ovr=0 without it.

Source files
------------

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Drives a bit-serial ALU through one WIDTH-bit operation.
//            Optional overrun flag enabled by macro ALU_SEQUENCER_OVR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovr,
  output logic             alu_rst_n,
  output logic [2:0]       alu_opcode,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_y,
  input  logic             alu_c
);

  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SHIFT  = 2'd2,
    S_SAMPLE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_CLEAR;
        end
      end
      S_CLEAR:  w_next = S_SHIFT;
      S_SHIFT: begin
        if (r_cnt == C_LAST) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= opcode_in;
            r_a    <= a_in;
            r_b    <= b_in;
            r_y    <= '0;
            r_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt <= '0;
        end
        S_SHIFT: begin
          // Operands leave LSB first; ALU result bits enter at the MSB end.
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_y   <= {alu_y, r_y[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_SAMPLE: begin
          r_result <= r_y;
          r_carry  <= alu_c;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQUENCER_OVR_EN
  logic r_ovr;

  // Sticky until reset or the next accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_accept) begin
      r_ovr <= 1'b0;
    end else if (start && r_busy) begin
      r_ovr <= 1'b1;
    end
  end

  assign ovr = r_ovr;
`else
  assign ovr = 1'b0;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign carry      = r_carry;
  assign alu_opcode = r_op;
  assign alu_rst_n  = ~(rst | (r_state == S_CLEAR));
  assign alu_a      = (r_state == S_SHIFT) & r_a[0];
  assign alu_b      = (r_state == S_SHIFT) & r_b[0];

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with a behavioural
//            bit-serial ALU attached. Honours ALU_SEQUENCER_OVR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       opcode_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovr;
  logic             alu_rst_n;
  logic [2:0]       alu_opcode;
  logic             alu_a;
  logic             alu_b;
  logic             alu_y;
  logic             alu_c;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode_in  (opcode_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry      (carry),
    .ovr        (ovr),
    .alu_rst_n  (alu_rst_n),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_c      (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bit-serial ALU: combinational y, registered carry/flag.
  logic m_c;
  logic m_y;
  logic m_cn;

  always_comb begin
    m_y  = 1'b0;
    m_cn = m_c;
    case (alu_opcode)
      3'd0: begin m_y = alu_a ^ alu_b ^ m_c;  m_cn = (alu_a & alu_b) | (alu_a & m_c) | (alu_b & m_c); end
      3'd1: begin m_y = alu_a ^ ~alu_b ^ m_c; m_cn = (alu_a & ~alu_b) | (alu_a & m_c) | (~alu_b & m_c); end
      3'd2: begin m_y = alu_a | alu_b;        m_cn = m_c | m_y; end
      3'd3: begin m_y = alu_a & alu_b;        m_cn = m_c | m_y; end
      3'd4: begin m_y = alu_a ^ alu_b;        m_cn = m_c | m_y; end
      3'd5: begin m_y = alu_a;                m_cn = m_c & ~(alu_a ^ alu_b); end
      3'd6: begin m_y = alu_a;                m_cn = (alu_a & ~alu_b) | (~(alu_a ^ alu_b) & m_c); end
      default: begin m_y = alu_b;             m_cn = m_c | alu_b; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!alu_rst_n) m_c <= (alu_opcode == 3'd1) || (alu_opcode == 3'd5) || (alu_opcode == 3'd6);
    else            m_c <= m_cn;
  end

  assign alu_y = m_y;
  assign alu_c = m_c;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             c;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done pops one expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result",  32'(result), 32'(mon_e.res));
        chk("carry",   32'(carry),  32'(mon_e.c));
        chk("latency", 32'(cyc),    32'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res,
                       input logic c);
    @(negedge clk);
    opcode_in = op;
    a_in      = a;
    b_in      = b;
    start     = 1'b1;
    sb.push_back('{res, c, cyc + 11});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("alu_opcode", 32'(alu_opcode), 32'(op));
    chk("alu_rst_n_clear", 32'(alu_rst_n), 32'd0);
  endtask

  task automatic wait_empty(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end else begin
      chk("done_high", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("idle_operands", 32'({alu_a, alu_b}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  vec_t vecs[13];
  int   s;
  int   dc;

  initial begin
    vecs[0]  = '{3'd0, 8'd200, 8'd100, 8'd44,  1'b1};
    vecs[1]  = '{3'd6, 8'd9,   8'd4,   8'd9,   1'b1};
    vecs[2]  = '{3'd5, 8'h5A,  8'h5A,  8'h5A,  1'b1};
    vecs[3]  = '{3'd1, 8'd5,   8'd3,   8'd2,   1'b1};
    vecs[4]  = '{3'd2, 8'h0F,  8'hF0,  8'hFF,  1'b1};
    vecs[5]  = '{3'd1, 8'd3,   8'd5,   8'hFE,  1'b0};
    vecs[6]  = '{3'd6, 8'd4,   8'd9,   8'd4,   1'b0};
    vecs[7]  = '{3'd5, 8'h5A,  8'h5B,  8'h5A,  1'b0};
    vecs[8]  = '{3'd3, 8'h0F,  8'hF0,  8'h00,  1'b0};
    vecs[9]  = '{3'd4, 8'h5A,  8'h0F,  8'h55,  1'b1};
    vecs[10] = '{3'd7, 8'h12,  8'h00,  8'h00,  1'b0};
    vecs[11] = '{3'd7, 8'h00,  8'h80,  8'h80,  1'b1};
    vecs[12] = '{3'd0, 8'hFF,  8'h01,  8'h00,  1'b1};

    rst = 1'b1; start = 1'b0; opcode_in = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_done",   32'(done),      32'd0);
    chk("rst_result", 32'(result),    32'd0);
    chk("rst_carry",  32'(carry),     32'd0);
    chk("rst_ovr",    32'(ovr),       32'd0);
    chk("rst_alurst", 32'(alu_rst_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_alurst", 32'(alu_rst_n), 32'd1);
    chk("idle_ab",     32'({alu_a, alu_b}), 32'd0);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c);
      wait_empty(30);
    end

    // Back-to-back with start held: second accept lands in the done cycle.
    @(negedge clk);
    s = cyc;
    opcode_in = 3'd1; a_in = 8'd5; b_in = 8'd3; start = 1'b1;
    sb.push_back('{8'd2,   1'b1, s + 11});
    sb.push_back('{8'hFE,  1'b0, s + 22});
    @(negedge clk);
    a_in = 8'd3; b_in = 8'd5;
    repeat (11) @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_empty(40);

    // Reset during SHIFT bit 3: abort with no done.
    @(negedge clk);
    s = cyc;
    opcode_in = 3'd0; a_in = 8'hFF; b_in = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_alurst", 32'(alu_rst_n), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_done",   32'(done),   32'd0);
    dc = done_cnt;
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(dc));
    issue(3'd2, 8'h0F, 8'hF0, 8'hFF, 1'b1);
    wait_empty(30);

    // Start while busy: ignored, optionally flagged.
    @(negedge clk);
    s = cyc;
    opcode_in = 3'd0; a_in = 8'd200; b_in = 8'd100; start = 1'b1;
    sb.push_back('{8'd44, 1'b1, s + 11});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    opcode_in = 3'd3; a_in = 8'd1; b_in = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = done_cnt;
    wait_empty(30);
`ifdef ALU_SEQUENCER_OVR_EN
    chk("ovr_set", 32'(ovr), 32'd1);
`else
    chk("ovr_set", 32'(ovr), 32'd0);
`endif
    repeat (12) @(negedge clk);
    chk("overrun_single_done", 32'(done_cnt), 32'(dc + 1));
    issue(3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b1);
    chk("ovr_cleared", 32'(ovr), 32'd0);
    wait_empty(30);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
